// File: rtl/mem_responder.sv
// Byte-addressed memory responder with programmable wait states.
// Define MEM_ALIGN_CHECK_EN to flag misaligned word accesses via MemErr.
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_BYTES = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        MemLength,
  input  logic        MemEnable,
  output logic [31:0] DataOut,
  output logic        MemRdy,
  output logic        MemErr,
  output logic        Busy
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WLAST =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic rd_q, wr_q;
  logic arm_q;
  logic acc_q;

  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          len_q;
  logic          dir_wr_q;

  logic rise_rd, rise_wr;
  logic accept;
  logic go_resp;
  logic misalign;

  logic [AW-1:0] b0, b1, b2, b3;
  logic [31:0]   rdata;

  logic [7:0] mem_q [DEPTH_BYTES];

  logic unused_addr;
  assign unused_addr = ^Addr[31:AW];

  assign rise_rd = MemRd & ~rd_q;
  assign rise_wr = MemWr & ~wr_q;

  // arm_q blocks a level that was already high when reset released.
  assign accept = arm_q & ~acc_q
                & (state_q == IDLE)
                & MemEnable
                & (rise_rd ^ rise_wr);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      arm_q <= 1'b0;
      acc_q <= 1'b0;
    end else begin
      rd_q  <= MemRd;
      wr_q  <= MemWr;
      arm_q <= 1'b1;
      acc_q <= accept;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      len_q    <= 1'b0;
      dir_wr_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= Addr[AW-1:0];
      wdata_q  <= DataIn;
      len_q    <= MemLength;
      dir_wr_q <= rise_wr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc_q) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WLAST) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = len_q & (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign b0 = {addr_q[AW-1:2], 2'b00};
  assign b1 = {addr_q[AW-1:2], 2'b01};
  assign b2 = {addr_q[AW-1:2], 2'b10};
  assign b3 = {addr_q[AW-1:2], 2'b11};

  assign rdata = len_q
    ? {mem_q[b3], mem_q[b2], mem_q[b1], mem_q[b0]}
    : {24'b0, mem_q[addr_q]};

  // Storage is deliberately not reset; contents survive Reset.
  always_ff @(posedge Clk) begin
    if (go_resp & dir_wr_q & ~misalign) begin
      if (len_q) begin
        mem_q[b0] <= wdata_q[7:0];
        mem_q[b1] <= wdata_q[15:8];
        mem_q[b2] <= wdata_q[23:16];
        mem_q[b3] <= wdata_q[31:24];
      end else begin
        mem_q[addr_q] <= wdata_q[7:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataOut <= 32'd0;
    end else if (go_resp & ~dir_wr_q & ~misalign) begin
      DataOut <= rdata;
    end
  end

  assign MemRdy = (state_q == RESP);
  assign MemErr = MemRdy & misalign;
  assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0).
module tb_mem_responder;

  logic        Clk;
  logic        Reset;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic        MemRd;
  logic        MemWr;
  logic        MemLength;
  logic        MemEnable;

  logic [31:0] DataOut, DataOut0;
  logic        MemRdy, MemRdy0;
  logic        MemErr, MemErr0;
  logic        Busy, Busy0;

  int errors = 0;
  int checks = 0;

  mem_responder #(.WAIT_CYCLES(2), .DEPTH_BYTES(256)) u_dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataIn(DataIn),
    .MemRd(MemRd), .MemWr(MemWr), .MemLength(MemLength),
    .MemEnable(MemEnable), .DataOut(DataOut), .MemRdy(MemRdy),
    .MemErr(MemErr), .Busy(Busy)
  );

  mem_responder #(.WAIT_CYCLES(0), .DEPTH_BYTES(256)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataIn(DataIn),
    .MemRd(MemRd), .MemWr(MemWr), .MemLength(MemLength),
    .MemEnable(MemEnable), .DataOut(DataOut0), .MemRdy(MemRdy0),
    .MemErr(MemErr0), .Busy(Busy0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit sel, input bit wr, input bit len,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int busy_n,
                        output logic err);
    @(negedge Clk);
    Addr = a; DataIn = d; MemLength = len;
    MemEnable = 1'b1; MemRd = !wr; MemWr = wr;
    @(posedge Clk);
    lat = 0; busy_n = 0; err = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge Clk); #1;
      if (sel ? Busy0 : Busy) busy_n++;
      if (sel ? MemRdy0 : MemRdy) begin
        lat = k;
        err = sel ? MemErr0 : MemErr;
      end
    end
    @(negedge Clk);
    MemRd = 1'b0; MemWr = 1'b0; MemEnable = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  task automatic count_win(input int n, output int rdy_n,
                           output int busy_n);
    rdy_n = 0; busy_n = 0;
    repeat (n) begin
      @(posedge Clk); #1;
      if (MemRdy) rdy_n++;
      if (Busy) busy_n++;
    end
  endtask

  int lat, bsy, rc, bc;
  logic err;
  logic [31:0] exp_d, exp_e;

  initial begin
    Reset = 1'b1; Addr = '0; DataIn = '0; MemRd = 1'b0;
    MemWr = 1'b0; MemLength = 1'b0; MemEnable = 1'b0;
    #2;
    check("rst_dataout", DataOut, 32'h0);
    check("rst_rdy", {31'b0, MemRdy}, 32'h0);
    check("rst_err", {31'b0, MemErr}, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    access(0, 1, 1, 32'h10, 32'hDEADBEEF, lat, bsy, err);
    check("wr10_lat", lat, 3);
    check("wr10_busy", bsy, 3);
    check("wr10_dout", DataOut, 32'h0);
    access(0, 0, 1, 32'h10, 32'h0, lat, bsy, err);
    check("rd10_lat", lat, 3);
    check("rd10_data", DataOut, 32'hDEADBEEF);
    check("rd10_err", {31'b0, err}, 32'h0);

    access(1, 0, 1, 32'h10, 32'h0, lat, bsy, err);
    check("w0_lat", lat, 1);
    check("w0_busy", bsy, 1);
    check("w0_data", DataOut0, 32'hDEADBEEF);

    access(0, 1, 0, 32'h11, 32'hFFFFFF5A, lat, bsy, err);
    check("wrb11_lat", lat, 3);
    access(0, 0, 1, 32'h10, 32'h0, lat, bsy, err);
    check("rd10_b", DataOut, 32'hDEAD5AEF);
    access(0, 0, 0, 32'h13, 32'h0, lat, bsy, err);
    check("rdb13", DataOut, 32'h000000DE);
    access(0, 1, 1, 32'h120, 32'h11223344, lat, bsy, err);
    check("wr_hold_dout", DataOut, 32'h000000DE);
    access(0, 0, 1, 32'h20, 32'h0, lat, bsy, err);
    check("wrap_rd20", DataOut, 32'h11223344);
    access(0, 0, 0, 32'h1023, 32'h0, lat, bsy, err);
    check("wrap_rdb23", DataOut, 32'h00000011);

    @(negedge Clk);
    Addr = 32'h20; DataIn = 32'h12345678; MemLength = 1'b1;
    MemEnable = 1'b1; MemWr = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1;
    check("mid_busy", {31'b0, Busy}, 32'h1);
    @(negedge Clk);
    Reset = 1'b1; MemWr = 1'b0; MemEnable = 1'b0;
    count_win(3, rc, bc);
    check("rst_mid_busy", bc, 0);
    check("rst_mid_dout", DataOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    count_win(6, rc, bc);
    check("rst_mid_rdy", rc, 0);
    access(0, 0, 1, 32'h20, 32'h0, lat, bsy, err);
    check("rst_mid_keep", DataOut, 32'h11223344);

    @(negedge Clk);
    Reset = 1'b1; MemEnable = 1'b1; MemLength = 1'b1;
    Addr = 32'h10; MemRd = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    count_win(8, rc, bc);
    check("lvl_thru_rst", rc, 0);
    @(negedge Clk);
    MemRd = 1'b0; MemEnable = 1'b0;
    repeat (2) @(posedge Clk);

    @(negedge Clk);
    Addr = 32'h10; MemLength = 1'b1; MemEnable = 1'b1; MemRd = 1'b1;
    count_win(10, rc, bc);
    @(negedge Clk);
    MemRd = 1'b0; MemEnable = 1'b0;
    check("held_one_rdy", rc, 1);
    check("held_data", DataOut, 32'hDEAD5AEF);
    repeat (2) @(posedge Clk);

    @(negedge Clk);
    Addr = 32'h10; DataIn = 32'hFFFFFFFF; MemLength = 1'b1;
    MemEnable = 1'b1; MemRd = 1'b1; MemWr = 1'b1;
    count_win(8, rc, bc);
    check("both_rdy", rc, 0);
    check("both_busy", bc, 0);
    @(negedge Clk);
    MemRd = 1'b0; MemWr = 1'b0; MemEnable = 1'b0;
    repeat (2) @(posedge Clk);
    access(0, 0, 0, 32'h13, 32'h0, lat, bsy, err);
    access(0, 0, 1, 32'h10, 32'h0, lat, bsy, err);
    check("both_nowrite", DataOut, 32'hDEAD5AEF);

    @(negedge Clk);
    MemEnable = 1'b0; MemRd = 1'b1;
    count_win(8, rc, bc);
    check("en_low_rdy", rc, 0);
    @(negedge Clk);
    MemRd = 1'b0;
    repeat (2) @(posedge Clk);

    access(0, 0, 0, 32'h13, 32'h0, lat, bsy, err);
    @(negedge Clk);
    Addr = 32'h10; MemLength = 1'b1; MemEnable = 1'b1; MemRd = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    MemEnable = 1'b0;
    count_win(8, rc, bc);
    check("en_drop_rdy", rc, 1);
    check("en_drop_data", DataOut, 32'hDEAD5AEF);
    @(negedge Clk);
    MemRd = 1'b0;
    repeat (2) @(posedge Clk);

    access(0, 1, 1, 32'h0, 32'hCAFEF00D, lat, bsy, err);
    access(0, 0, 0, 32'h13, 32'h0, lat, bsy, err);
    check("pre_mis", DataOut, 32'h000000DE);
`ifdef MEM_ALIGN_CHECK_EN
    exp_d = 32'h000000DE;
    exp_e = 32'h1;
`else
    exp_d = 32'hCAFEF00D;
    exp_e = 32'h0;
`endif
    access(0, 0, 1, 32'h102, 32'h0, lat, bsy, err);
    check("mis_lat", lat, 3);
    check("mis_err", {31'b0, err}, exp_e);
    check("mis_data", DataOut, exp_d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
